// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the parametrised convolution engine.
package conv_pkg;

    // Engine control states; also exported on the debug state port.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Accumulator width: full product plus growth for DEPTH additions.
    function automatic int acc_width(input int width, input int depth);
        return 2 * width + $clog2(depth);
    endfunction

    // Number of DSP_NO-wide channel groups needed to cover COUT.
    function automatic int groups(input int cout, input int dsp_no);
        return (cout + dsp_no - 1) / dsp_no;
    endfunction

    // Requantise one lane: add bias, optional round-half-up, arithmetic shift,
    // saturate to the output word range, optional ReLU.
    // Arithmetic is carried out at 64 bits, which holds any ACC_W below 63.
    function automatic logic signed [63:0] requant(
        input logic signed [63:0] acc,
        input logic signed [63:0] bias,
        input int                 frac,
        input logic               round_en,
        input logic               relu_en,
        input int                 width
    );
        logic signed [63:0] s;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        s = acc + bias;
        if (round_en && frac > 0) begin
            s = s + (64'sd1 <<< (frac - 1));
        end
        s = s >>> frac;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (s > max_v) begin
            s = max_v;
        end else if (s < min_v) begin
            s = min_v;
        end
        if (relu_en && s < 64'sd0) begin
            s = 64'sd0;
        end
        return s;
    endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One MAC lane: signed pixel x weight product accumulated over a window.
module conv_mac_lane
    import conv_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ACC_W = 43
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] pix_i,
    input  logic signed [WIDTH-1:0] ker_i,
    input  logic                    first_i,
    input  logic                    en_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   acc_d;

    assign prod = pix_i * ker_i;

    // First beat of a window restarts the sum; later beats add on.
    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            if (first_i) begin
                acc_d = ACC_W'(prod);
            end else begin
                acc_d = acc_q + ACC_W'(prod);
            end
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/conv_engine_param.sv
// Parametrised KxKxCHIN -> COUT convolution engine with DSP_NO MAC lanes.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never depends on ready, and data is held while
// valid is high and ready is low.
module conv_engine_param
    import conv_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 14,
    parameter int DSP_NO     = 32,
    parameter int CHIN       = 128,
    parameter int KERNEL_DIM = 3,
    parameter int COUT       = 32,
    parameter int WOUT       = 32,
    parameter int RELU       = 1,
    parameter int ROUND      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    input  logic [WIDTH-1:0]     ifm_i,
    input  logic                 ifm_valid_i,
    output logic                 ifm_ready_o,
    output logic [$clog2(((COUT+DSP_NO-1)/DSP_NO)*KERNEL_DIM*KERNEL_DIM*CHIN)-1:0] w_addr_o,
    input  logic [DSP_NO*WIDTH-1:0]   w_data_i,
    output logic [$clog2((COUT+DSP_NO-1)/DSP_NO):0] grp_o,
    input  logic [DSP_NO*2*WIDTH-1:0] bias_i,
    output logic [DSP_NO*WIDTH-1:0]   ofm_o,
    output logic [DSP_NO-1:0]         ofm_lane_valid_o,
    output logic                 ofm_valid_o,
    input  logic                 ofm_ready_i,
    output logic [2:0]           state_o
);

    localparam int DEPTH  = KERNEL_DIM * KERNEL_DIM * CHIN;
    localparam int GROUPS = groups(COUT, DSP_NO);
    localparam int ACC_W  = acc_width(WIDTH, DEPTH);
    localparam int AW     = $clog2(GROUPS * DEPTH);
    localparam int GW     = $clog2(GROUPS) + 1;
    localparam int BW     = $clog2(DEPTH) + 1;
    localparam int PIXELS = WOUT * WOUT;
    localparam int PW     = $clog2(PIXELS) + 1;

    state_t            state_q, state_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic              drain_q, drain_d;
    logic [GW-1:0]     grp_q, grp_d;
    logic [PW-1:0]     pix_cnt_q, pix_cnt_d;
    logic              capture;
    logic              accept;

    logic [WIDTH-1:0]  pix_q;
    logic              v_q;
    logic              first_q;

    logic signed [ACC_W-1:0] acc [DSP_NO];
    logic [DSP_NO*WIDTH-1:0] ofm_q, ofm_d;
    logic [DSP_NO-1:0]       mask_q, mask_d;

    assign accept = (state_q == RUN) && ifm_valid_i;

    // Next-state, counter updates and handshake outputs.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        drain_d     = drain_q;
        grp_d       = grp_q;
        pix_cnt_d   = pix_cnt_q;
        capture     = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        ifm_ready_o = 1'b0;
        ofm_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = RUN;
                    beat_cnt_d = '0;
                    grp_d      = '0;
                    pix_cnt_d  = '0;
                end
            end
            RUN: begin
                busy_o      = 1'b1;
                ifm_ready_o = 1'b1;
                if (ifm_valid_i) begin
                    if (beat_cnt_q == BW'(DEPTH - 1)) begin
                        beat_cnt_d = '0;
                        drain_d    = 1'b0;
                        state_d    = DRAIN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Two cycles: weight read, then the last accumulate.
                busy_o = 1'b1;
                if (drain_q) begin
                    capture = 1'b1;
                    state_d = OUT;
                end else begin
                    drain_d = 1'b1;
                end
            end
            OUT: begin
                busy_o      = 1'b1;
                ofm_valid_o = 1'b1;
                if (ofm_ready_i) begin
                    if (grp_q == GW'(GROUPS - 1)) begin
                        grp_d = '0;
                        if (pix_cnt_q == PW'(PIXELS - 1)) begin
                            pix_cnt_d = '0;
                            state_d   = DONE;
                        end else begin
                            pix_cnt_d = pix_cnt_q + 1'b1;
                            state_d   = RUN;
                        end
                    end else begin
                        grp_d   = grp_q + 1'b1;
                        state_d = RUN;
                    end
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            drain_q    <= 1'b0;
            grp_q      <= '0;
            pix_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            drain_q    <= drain_d;
            grp_q      <= grp_d;
            pix_cnt_q  <= pix_cnt_d;
        end
    end

    // Delay the accepted pixel one cycle to line up with the weight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q   <= '0;
            v_q     <= 1'b0;
            first_q <= 1'b0;
        end else begin
            v_q     <= accept;
            first_q <= accept && (beat_cnt_q == '0);
            if (accept) begin
                pix_q <= ifm_i;
            end
        end
    end

    for (genvar l = 0; l < DSP_NO; l++) begin : g_lane
        conv_mac_lane #(
            .WIDTH (WIDTH),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .pix_i   (pix_q),
            .ker_i   (w_data_i[l*WIDTH +: WIDTH]),
            .first_i (first_q),
            .en_i    (v_q),
            .acc_o   (acc[l])
        );
    end

    // Requantise every lane; lanes past COUT in the last group read as 0.
    always_comb begin
        ofm_d  = '0;
        mask_d = '0;
        for (int l = 0; l < DSP_NO; l++) begin
            if (int'(grp_q) * DSP_NO + l < COUT) begin
                mask_d[l] = 1'b1;
                ofm_d[l*WIDTH +: WIDTH] = WIDTH'(requant(
                    64'(acc[l]),
                    64'($signed(bias_i[l*2*WIDTH +: 2*WIDTH])),
                    FRAC, ROUND != 0, RELU != 0, WIDTH));
            end
        end
    end

    // Result register, loaded once per window and held through backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            ofm_q  <= '0;
            mask_q <= '0;
        end else if (capture) begin
            ofm_q  <= ofm_d;
            mask_q <= mask_d;
        end
    end

    assign ofm_o            = ofm_q;
    assign ofm_lane_valid_o = mask_q;
    assign grp_o            = grp_q;
    assign w_addr_o         = AW'(int'(grp_q) * DEPTH + int'(beat_cnt_q));
    assign state_o          = state_q;

endmodule

// File: tb/tb_conv_engine_param.sv
// Directed bench for conv_engine_param: one ReLU and one non-ReLU instance
// share stimulus; weights come from a 1-cycle-latency memory model.
module tb_conv_engine_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] ifm;
  logic        ifm_valid;
  logic        ofm_ready;

  logic        busy_a, done_a, ifm_ready_a, valid_a;
  logic [2:0]  w_addr_a, state_a;
  logic [31:0] w_data_a, ofm_a;
  logic [1:0]  grp_a, mask_a;
  logic [63:0] bias_a;

  logic        busy_b, done_b, ifm_ready_b, valid_b;
  logic [2:0]  w_addr_b, state_b;
  logic [31:0] w_data_b, ofm_b;
  logic [1:0]  grp_b, mask_b;
  logic [63:0] bias_b;

  logic [31:0] wmem [8];
  logic [63:0] bias_mem [4];

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int done_cnt = 0;

  // layer 1 windows: pixel value, expected {lane1,lane0} for ReLU / no-ReLU
  logic [15:0] l1_pix [8] = '{16'h0100, 16'h0100, 16'h7F00, 16'h7F00,
                              16'h0000, 16'h0000, 16'hFF00, 16'hFF00};
  logic [31:0] l1_ea  [8] = '{32'h0000_0200, 32'h0000_7FFF, 32'h0000_7FFF, 32'h0000_7FFF,
                              32'h0000_0000, 32'h0000_0000, 32'h0200_0000, 32'h0000_0000};
  logic [31:0] l1_eb  [8] = '{32'hFE00_0200, 32'h0000_7FFF, 32'h8000_7FFF, 32'h0000_7FFF,
                              32'h0000_0000, 32'h0000_0000, 32'h0200_FE00, 32'h0000_8000};
  // layer 2 windows: same result on both instances
  logic [15:0] l2_pix [8] = '{16'h0100, 16'h0100, 16'h0000, 16'h0000,
                              16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [31:0] l2_e   [8] = '{32'h0200_0200, 32'h0000_0201, 32'h0000_0000, 32'h0000_0001,
                              32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001};

  conv_engine_param #(
    .WIDTH(16), .FRAC(8), .DSP_NO(2), .CHIN(4), .KERNEL_DIM(1),
    .COUT(3), .WOUT(2), .RELU(1), .ROUND(1)
  ) dut_a (
    .clk(clk), .rst(rst), .start_i(start), .busy_o(busy_a), .done_o(done_a),
    .ifm_i(ifm), .ifm_valid_i(ifm_valid), .ifm_ready_o(ifm_ready_a),
    .w_addr_o(w_addr_a), .w_data_i(w_data_a), .grp_o(grp_a), .bias_i(bias_a),
    .ofm_o(ofm_a), .ofm_lane_valid_o(mask_a), .ofm_valid_o(valid_a),
    .ofm_ready_i(ofm_ready), .state_o(state_a)
  );

  conv_engine_param #(
    .WIDTH(16), .FRAC(8), .DSP_NO(2), .CHIN(4), .KERNEL_DIM(1),
    .COUT(3), .WOUT(2), .RELU(0), .ROUND(1)
  ) dut_b (
    .clk(clk), .rst(rst), .start_i(start), .busy_o(busy_b), .done_o(done_b),
    .ifm_i(ifm), .ifm_valid_i(ifm_valid), .ifm_ready_o(ifm_ready_b),
    .w_addr_o(w_addr_b), .w_data_i(w_data_b), .grp_o(grp_b), .bias_i(bias_b),
    .ofm_o(ofm_b), .ofm_lane_valid_o(mask_b), .ofm_valid_o(valid_b),
    .ofm_ready_i(ofm_ready), .state_o(state_b)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // weight memory model and bias select
  always @(posedge clk) begin
    w_data_a <= wmem[w_addr_a];
    w_data_b <= wmem[w_addr_b];
  end
  assign bias_a = bias_mem[grp_a];
  assign bias_b = bias_mem[grp_b];

  // handshake and done monitors
  always @(posedge clk) begin
    if (!rst) begin
      if (valid_a && ofm_ready) hs_cnt <= hs_cnt + 1;
      if (done_a) done_cnt <= done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  {busy_a, busy_b}, 2'b00);
    check({tag, "_done"},  {done_a, done_b}, 2'b00);
    check({tag, "_irdy"},  {ifm_ready_a, ifm_ready_b}, 2'b00);
    check({tag, "_valid"}, {valid_a, valid_b}, 2'b00);
    check({tag, "_ofm"},   {ofm_b, ofm_a}, 64'h0);
    check({tag, "_mask"},  {mask_b, mask_a}, 4'h0);
    check({tag, "_addr"},  {w_addr_b, w_addr_a}, 6'h0);
    check({tag, "_grp"},   {grp_b, grp_a}, 4'h0);
    check({tag, "_state"}, {state_b, state_a}, 6'h0);
  endtask

  // driver tasks
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {busy_a, busy_b}, 2'b11);
  endtask

  task automatic send_beat(input logic [15:0] pix);
    int n;
    repeat ($urandom_range(0, 1)) tick();
    ifm = pix;
    ifm_valid = 1'b1;
    n = 0;
    while (!ifm_ready_a && n < 50) begin
      tick();
      n++;
    end
    check("beat_ready", ifm_ready_a, 1'b1);
    tick();
    ifm_valid = 1'b0;
  endtask

  task automatic run_window(input logic [15:0] pix, input logic [31:0] ea, input logic [31:0] eb,
                            input logic [1:0] em, input logic [1:0] eg, input bit bp);
    int n;
    for (int b = 0; b < 4; b++) send_beat(pix);
    n = 0;
    while (!valid_a && n < 20) begin
      tick();
      n++;
    end
    check("valid_rise", {valid_a, valid_b}, 2'b11);
    check("latency", n, 2);
    check("ofm_relu", ofm_a, ea);
    check("ofm_norelu", ofm_b, eb);
    check("mask", {mask_b, mask_a}, {em, em});
    check("grp", {grp_b, grp_a}, {eg, eg});
    check("irdy_in_out", ifm_ready_a, 1'b0);
    if (bp) begin
      ifm = 16'h1234;
      ifm_valid = 1'b1;
      repeat (5) tick();
      check("bp_ofm_relu", ofm_a, ea);
      check("bp_ofm_norelu", ofm_b, eb);
      check("bp_irdy", {ifm_ready_a, ifm_ready_b}, 2'b00);
      check("bp_valid", {valid_a, valid_b}, 2'b11);
      ifm_valid = 1'b0;
    end
    ofm_ready = 1'b1;
    tick();
    ofm_ready = 1'b0;
  endtask

  task automatic check_layer_end(input int hs0, input int dn0);
    check("done_pulse", {done_a, done_b}, 2'b11);
    check("busy_in_done", {busy_a, busy_b}, 2'b00);
    tick();
    check("done_low", {done_a, done_b}, 2'b00);
    check("idle_after_done", state_a, 3'd0);
    check("handshakes", hs_cnt - hs0, 8);
    check("done_count", done_cnt - dn0, 1);
  endtask

  initial begin
    int hs0;
    int dn0;
    rst = 1'b1;
    start = 1'b0;
    ifm = '0;
    ifm_valid = 1'b0;
    ofm_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wmem[i]     = {16'hFF80, 16'h0080};
      wmem[i + 4] = {16'h0080, 16'h7F00};
      bias_mem[i] = 64'h0;
    end
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // layer 1: arithmetic, saturation, ReLU, partial group, backpressure
    hs0 = hs_cnt;
    dn0 = done_cnt;
    do_start();
    for (int w = 0; w < 8; w++) begin
      run_window(l1_pix[w], l1_ea[w], l1_eb[w], (w % 2 == 0) ? 2'b11 : 2'b01,
                 2'(w % 2), w == 2);
    end
    check_layer_end(hs0, dn0);

    // start while busy is ignored: only a single pulse is honoured
    for (int i = 0; i < 8; i++) wmem[i] = {16'h0080, 16'h0080};
    bias_mem[1] = 64'h0000_0000_0000_0080;

    // reset in the middle of a window
    do_start();
    send_beat(16'h0100);
    send_beat(16'h0100);
    rst = 1'b1;
    tick();
    check_idle_outputs("midreset");
    rst = 1'b0;
    tick();

    // layer 2: restart after reset, bias rounding
    hs0 = hs_cnt;
    dn0 = done_cnt;
    do_start();
    for (int w = 0; w < 8; w++) begin
      if (w == 1) begin
        start = 1'b1;
      end
      run_window(l2_pix[w], l2_e[w], l2_e[w], (w % 2 == 0) ? 2'b11 : 2'b01,
                 2'(w % 2), 1'b0);
      start = 1'b0;
    end
    check_layer_end(hs0, dn0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_engine_param.md
Name: conv_engine_param

Overview:
- Generalised, parametrised successor of the per-layer squeeze-convolution blocks: one engine for any K×K×CHIN → COUT convolution layer.
- Array of DSP_NO MAC lanes; processes COUT in ceil(COUT/DSP_NO) channel groups per output pixel.
- Streams pixels in and weights from an external weight memory; adds bias, rounds, saturates, optionally applies ReLU.
- Emits one group of DSP_NO results per valid/ready handshake.
- Sits between a line-buffer/ifm sequencer upstream and the ofm RAM writer downstream.

Parameters:
- WIDTH, 16, pixel/weight/output word width (signed, two's complement).
- FRAC, 14, fractional bits of pixel, weight and output words.
- DSP_NO, 32, MAC lanes (output channels per group).
- CHIN, 128, input channels.
- KERNEL_DIM, 3, kernel side K.
- COUT, 32, output channels of the layer.
- WOUT, 32, output feature-map side.
- RELU, 1, 1 = clamp negative results to 0.
- ROUND, 1, 1 = round-half-up on requantisation; 0 = truncate.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  single-cycle pulse; begins a layer.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle pulse after the last output handshake.
- ifm_i  in  WIDTH  input pixel beat.
- ifm_valid_i  in  1  ifm_i valid.
- ifm_ready_o  out  1  engine accepts a beat this cycle.
- w_addr_o  out  clog2(GROUPS*DEPTH)  weight memory address.
- w_data_i  in  DSP_NO*WIDTH  weights for all lanes; 1-cycle read latency.
- grp_o  out  clog2(GROUPS)+1  current channel group (bias select).
- bias_i  in  DSP_NO*2*WIDTH  per-lane bias in Q(2*FRAC); stable while busy within a group.
- ofm_o  out  DSP_NO*WIDTH  results for the current group.
- ofm_lane_valid_o  out  DSP_NO  lane mask; 0 for lanes beyond COUT.
- ofm_valid_o  out  1  results valid.
- ofm_ready_i  in  1  downstream accepts results.

Behaviour:
- Constants: DEPTH = K*K*CHIN; GROUPS = ceil(COUT/DSP_NO); ACC_W = 2*WIDTH + clog2(DEPTH).
- Reset (also mid-operation): state IDLE. All counters cleared. busy_o, done_o, ifm_ready_o and ofm_valid_o are 0. ofm_o and ofm_lane_valid_o are 0. w_addr_o and grp_o are 0.
- FSM:
  - IDLE: waits for start_i; goes to RUN.
  - RUN: ifm_ready_o = 1. Every accepted beat (valid & ready) drives w_addr_o = grp*DEPTH + beat_cnt. After DEPTH accepted beats, goes to DRAIN.
  - DRAIN: 2 cycles, flushing the pipeline; goes to OUT.
  - OUT: ofm_valid_o held. On handshake, advance group then pixel. If more work remains, go to RUN; after the WOUT²·GROUPS-th handshake, go to DONE.
  - DONE: pulses done_o for 1 cycle, drops busy_o, returns to IDLE.
- ifm_ready_o is 0 outside RUN; beats presented then are ignored. start_i while busy is ignored.
- Upstream re-sends the DEPTH-beat window once per group.
- Pipeline: beat accepted at cycle T. w_data_i arrives at T+1, together with the pixel delayed 1 cycle. Lane accumulator updates at T+2. On the first beat of a window the accumulator loads the product instead of adding.
- Latency: ofm_valid_o rises at T_last+3. ofm_o and the mask stay stable until the handshake.
- Arithmetic per lane:
  - Product: signed 2*WIDTH.
  - Accumulator: ACC_W bits, no overflow possible.
  - Sum = acc + sign-extended bias.
  - If ROUND, add 2^(FRAC-1).
  - Arithmetic shift right by FRAC.
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - If RELU, negative results become 0.
- Last group: lanes with index ≥ COUT-g*DSP_NO output 0 and mask bit 0. All other mask bits are 1.
- Backpressure: OUT may last any number of cycles; no beat is accepted and no state is lost.
- ofm_valid_o is never asserted without a preceding complete window.

Decomposition:
- Package conv_pkg:
  - state enum (IDLE, RUN, DRAIN, OUT, DONE).
  - functions acc_width(), groups(), requant(acc, bias, FRAC, ROUND, RELU, WIDTH) covering round, saturate and ReLU.
- Sub-module conv_mac_lane (generated DSP_NO times):
  - inputs: pix, ker, first, en.
  - output: ACC_W accumulator.
- FSM, counters, address generation and output register stay in the top.

Test Plan (WIDTH=16, FRAC=8, K=1, CHIN=4, DSP_NO=2, COUT=3, WOUT=2, ROUND=1):
- Basic: all pix=0x0100 (1.0), all w=0x0080 (0.5), bias 0, RELU=1 -> every valid lane = 0x0200. ofm_valid_o rises 3 cycles after the 4th beat.
- Saturation: pix=0x7F00, w=0x7F00 -> 0x7FFF. pix=0x7F00, w=0x8100 with RELU=0 -> 0x8000.
- ReLU/rounding: w=0xFF80 (-0.5), pix=0x0100 -> RELU=1 gives 0x0000, RELU=0 gives 0xFE00. Bias 0x0000_0080 with pix=0, ROUND=1 -> 0x0001.
- Partial group and done: full layer -> exactly 8 handshakes. Groups alternate grp_o 0,1. Group 1 mask = 2'b01 with lane1 = 0. done_o pulses once, 1 cycle after the last handshake.
- Backpressure: hold ofm_ready_i=0 for 5 cycles -> ofm_o stable, ifm_ready_o=0, and the next window result is still correct.
- Reset mid-RUN after 2 beats -> next cycle all outputs 0, state IDLE. A new start_i then gives a correct first result (0x0200).
